// File: rtl/l1_l2_refill_ctrl_pkg.sv
// rtl/l1_l2_refill_ctrl_pkg.sv - shared state enum, default widths and address field helpers
// Package l1_l2_pkg: imported by plru_bits and l1_l2_refill_ctrl.
package l1_l2_pkg;

    localparam int DEF_ADDR_W         = 16;
    localparam int DEF_LINE_W         = 256;
    localparam int DEF_NUM_SETS       = 16;
    localparam int DEF_NUM_WAYS       = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        REQ,
        WAIT,
        FILL
    } state_t;

    // Helpers take a zero-extended 32-bit address; callers truncate to field width.
    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int offset_w);
        return addr & ((32'd1 << offset_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int offset_w,
                                               input int index_w);
        return (addr >> offset_w) & ((32'd1 << index_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int offset_w,
                                             input int index_w);
        return addr >> (offset_w + index_w);
    endfunction

endpackage

// File: rtl/l1_l2_refill_ctrl_plru_bits.sv
// rtl/l1_l2_refill_ctrl_plru_bits.sv - one set's bit-PLRU state with touch and victim select
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears all bits)
//   touch      update the bits for touch_way this cycle
//   touch_way  way being hit or filled
//   valid      per-way valid bits of this set (invalid ways win victim select)
//   victim     lowest invalid way, else lowest way whose PLRU bit is 0
module plru_bits
    import l1_l2_pkg::*;
#(
    parameter  int NUM_WAYS = DEF_NUM_WAYS,
    localparam int WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                touch,
    input  logic [WAY_W-1:0]    touch_way,
    input  logic [NUM_WAYS-1:0] valid,
    output logic [WAY_W-1:0]    victim
);

    logic [NUM_WAYS-1:0] bits_q;
    logic [NUM_WAYS-1:0] bits_set;
    logic [NUM_WAYS-1:0] way_onehot;
    logic                any_invalid;

    assign way_onehot = NUM_WAYS'(1) << touch_way;
    assign bits_set   = bits_q | way_onehot;

    // Never let every bit be 1: a zero bit must always exist for victim select.
    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
        end else if (touch) begin
            bits_q <= (&bits_set) ? way_onehot : bits_set;
        end
    end

    assign any_invalid = ~&valid;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        victim = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (any_invalid ? !valid[w] : !bits_q[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

endmodule

// File: rtl/l1_l2_refill_ctrl.sv
// rtl/l1_l2_refill_ctrl.sv - L1 tag/PLRU controller with L2 line refill engine
// Optional feature macro: L2_TIMEOUT_EN (L2 response watchdog, drives resp_err).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   lookup_valid/ready/addr        one lookup at a time, accepted only in IDLE
//   resp_valid/hit/way/err         one-cycle completion pulse (hit, refilled miss, or timeout)
//   l2_req_valid/ready/addr        line-aligned L2 request, held until accepted
//   l2_rsp_valid/data              L2 line return
//   fill_valid/set/way/data        one-cycle write strobe to the external L1 data array
module l1_l2_refill_ctrl
    import l1_l2_pkg::*;
#(
    parameter  int ADDR_W         = DEF_ADDR_W,
    parameter  int LINE_W         = DEF_LINE_W,
    parameter  int NUM_SETS       = DEF_NUM_SETS,
    parameter  int NUM_WAYS       = DEF_NUM_WAYS,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int OFFSET_W       = $clog2(LINE_W / 8),
    localparam int INDEX_W        = $clog2(NUM_SETS),
    localparam int WAY_W          = $clog2(NUM_WAYS),
    localparam int TAG_W          = ADDR_W - OFFSET_W - INDEX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lookup_valid,
    output logic                lookup_ready,
    input  logic [ADDR_W-1:0]   lookup_addr,
    output logic                resp_valid,
    output logic                resp_hit,
    output logic [WAY_W-1:0]    resp_way,
    output logic                resp_err,
    output logic                l2_req_valid,
    input  logic                l2_req_ready,
    output logic [ADDR_W-1:0]   l2_req_addr,
    input  logic                l2_rsp_valid,
    input  logic [LINE_W-1:0]   l2_rsp_data,
    output logic                fill_valid,
    output logic [INDEX_W-1:0]  fill_set,
    output logic [WAY_W-1:0]    fill_way,
    output logic [LINE_W-1:0]   fill_data
);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [WAY_W-1:0]    victim_q;
    logic [LINE_W-1:0]   data_q;
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];

    logic [INDEX_W-1:0]  cur_idx;
    logic [TAG_W-1:0]    cur_tag;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                plru_touch;
    logic [WAY_W-1:0]    plru_way;
    logic [WAY_W-1:0]    set_victim [NUM_SETS];
    logic                tmo_fire;
    logic                unused_offset;

    assign cur_idx       = INDEX_W'(addr_index(32'(addr_q), OFFSET_W, INDEX_W));
    assign cur_tag       = TAG_W'(addr_tag(32'(addr_q), OFFSET_W, INDEX_W));
    assign unused_offset = ^addr_offset(32'(addr_q), OFFSET_W);

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[cur_idx][w] && tag_q[cur_idx][w] == cur_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Only a hit (in COMPARE) or a fill touches PLRU; a timeout leaves it alone.
    assign plru_touch = (state == COMPARE && hit) || (state == FILL);
    assign plru_way   = (state == FILL) ? victim_q : hit_way;

    for (genvar s = 0; s < NUM_SETS; s++) begin : g_plru
        plru_bits #(.NUM_WAYS(NUM_WAYS)) u_plru (
            .clk       (clk),
            .rst       (rst),
            .touch     (plru_touch && cur_idx == INDEX_W'(s)),
            .touch_way (plru_way),
            .valid     (valid_q[s]),
            .victim    (set_victim[s])
        );
    end

`ifdef L2_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Held at zero outside WAIT, so it restarts on every entry into WAIT.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign tmo_fire = (state == WAIT) && !l2_rsp_valid && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (lookup_valid) state_nxt = COMPARE;
            COMPARE: state_nxt = hit ? IDLE : REQ;
            REQ:     if (l2_req_ready) state_nxt = WAIT;
            WAIT: begin
                if (l2_rsp_valid)  state_nxt = FILL;
                else if (tmo_fire) state_nxt = IDLE;
            end
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            victim_q <= '0;
            data_q   <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
            end
        end else begin
            if (state == IDLE && lookup_valid) addr_q <= lookup_addr;
            if (state == COMPARE) victim_q <= set_victim[cur_idx];
            if (state == WAIT && l2_rsp_valid) data_q <= l2_rsp_data;
            if (state == FILL) valid_q[cur_idx][victim_q] <= 1'b1;
        end
    end

    // Tag contents are don't-care until the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tag_q[cur_idx][victim_q] <= cur_tag;
        end
    end

    always_comb begin
        lookup_ready = (state == IDLE);
        resp_valid   = 1'b0;
        resp_hit     = 1'b0;
        resp_way     = '0;
        resp_err     = 1'b0;
        l2_req_valid = 1'b0;
        l2_req_addr  = '0;
        fill_valid   = 1'b0;
        fill_set     = '0;
        fill_way     = '0;
        fill_data    = '0;
        case (state)
            COMPARE: begin
                resp_valid = hit;
                resp_hit   = hit;
                resp_way   = hit ? hit_way : '0;
            end
            REQ: begin
                l2_req_valid = 1'b1;
                l2_req_addr  = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            end
            WAIT: begin
                resp_valid = tmo_fire;
                resp_err   = tmo_fire;
            end
            FILL: begin
                fill_valid = 1'b1;
                fill_set   = cur_idx;
                fill_way   = victim_q;
                fill_data  = data_q;
                resp_valid = 1'b1;
                resp_way   = victim_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_l1_l2_refill_ctrl.sv
// tb/tb_l1_l2_refill_ctrl.sv - self-checking bench for l1_l2_refill_ctrl (directed + random)
module tb_l1_l2_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         lookup_valid;
    logic         lookup_ready;
    logic [15:0]  lookup_addr;
    logic         resp_valid;
    logic         resp_hit;
    logic [1:0]   resp_way;
    logic         resp_err;
    logic         l2_req_valid;
    logic         l2_req_ready;
    logic [15:0]  l2_req_addr;
    logic         l2_rsp_valid;
    logic [255:0] l2_rsp_data;
    logic         fill_valid;
    logic [3:0]   fill_set;
    logic [1:0]   fill_way;
    logic [255:0] fill_data;

    int checks   = 0;
    int failures = 0;

    // Reference cache state: 16 sets x 4 ways.
    bit          mvalid [16][4];
    logic [6:0]  mtag   [16][4];
    bit          mplru  [16][4];

    l1_l2_refill_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_addr  (lookup_addr),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way),
        .resp_err     (resp_err),
        .l2_req_valid (l2_req_valid),
        .l2_req_ready (l2_req_ready),
        .l2_req_addr  (l2_req_addr),
        .l2_rsp_valid (l2_rsp_valid),
        .l2_rsp_data  (l2_rsp_data),
        .fill_valid   (fill_valid),
        .fill_set     (fill_set),
        .fill_way     (fill_way),
        .fill_data    (fill_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_find(input int s, input logic [6:0] t);
        for (int w = 0; w < 4; w++) if (mvalid[s][w] && mtag[s][w] == t) return w;
        return -1;
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++) if (!mvalid[s][w]) return w;
        for (int w = 0; w < 4; w++) if (!mplru[s][w]) return w;
        return 0;
    endfunction

    task automatic m_touch(input int s, input int w);
        int ones;
        mplru[s][w] = 1'b1;
        ones = 0;
        for (int v = 0; v < 4; v++) ones += int'(mplru[s][v]);
        if (ones == 4) for (int v = 0; v < 4; v++) mplru[s][v] = (v == w);
    endtask

    task automatic m_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                mvalid[s][w] = 1'b0;
                mplru[s][w]  = 1'b0;
            end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // mode 0: normal, 1: reset while in WAIT, 2: no L2 response (timeout build).
    task automatic do_lookup(input logic [15:0] addr, input int rdly, input int sdly,
                             input int mode, output int got_way);
        logic [6:0]   t;
        logic [15:0]  exp_req;
        logic [255:0] d;
        int s, hw, vw, n;
        t       = addr[15:9];
        s       = int'(addr[8:5]);
        hw      = m_find(s, t);
        exp_req = {addr[15:5], 5'b0};
        got_way = -1;
        n = 0;
        while (!lookup_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lookup_ready_idle", lookup_ready, 1);
        lookup_valid = 1'b1;
        lookup_addr  = addr;
        @(negedge clk);
        lookup_valid = 1'b0;
        lookup_addr  = 16'($urandom);
        check("resp_valid_compare", resp_valid, hw >= 0);
        check("lookup_ready_busy", lookup_ready, 0);
        if (hw >= 0) begin
            check("resp_hit", resp_hit, 1);
            check("resp_way_hit", resp_way, hw);
            check("no_l2_req_on_hit", l2_req_valid, 0);
            got_way = hw;
            m_touch(s, hw);
            @(negedge clk);
            check("ready_after_hit", lookup_ready, 1);
            check("resp_pulse_hit", resp_valid, 0);
            return;
        end
        vw = m_victim(s);
        @(negedge clk);
        check("l2_req_valid", l2_req_valid, 1);
        check("l2_req_addr", l2_req_addr, exp_req);
        repeat (rdly) begin
            @(negedge clk);
            check("l2_req_valid_hold", l2_req_valid, 1);
            check("l2_req_addr_hold", l2_req_addr, exp_req);
        end
        l2_req_ready = 1'b1;
        @(negedge clk);
        l2_req_ready = 1'b0;
        check("l2_req_drop_after_hs", l2_req_valid, 0);
        if (mode == 1) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            m_reset();
            check("rst_lookup_ready", lookup_ready, 1);
            check("rst_l2_req_valid", l2_req_valid, 0);
            check("rst_resp_valid", resp_valid, 0);
            check("rst_fill_valid", fill_valid, 0);
            l2_rsp_valid = 1'b1;
            l2_rsp_data  = rand_line();
            @(negedge clk);
            l2_rsp_valid = 1'b0;
            check("late_rsp_no_fill", fill_valid, 0);
            check("late_rsp_no_resp", resp_valid, 0);
            @(negedge clk);
            check("late_rsp_no_fill_2", fill_valid, 0);
            return;
        end
        if (mode == 2) begin
            n = 0;
            while (!resp_valid && n < 200) begin
                check("no_fill_while_waiting", fill_valid, 0);
                @(negedge clk);
                n++;
            end
            check("timeout_wait_cycles", n, 63);
            check("timeout_resp_err", resp_err, 1);
            check("timeout_resp_hit", resp_hit, 0);
            check("timeout_no_fill", fill_valid, 0);
            @(negedge clk);
            check("timeout_ready_next", lookup_ready, 1);
            check("timeout_pulse", resp_valid, 0);
            l2_rsp_valid = 1'b1;
            @(negedge clk);
            l2_rsp_valid = 1'b0;
            check("timeout_late_rsp_no_fill", fill_valid, 0);
            return;
        end
        repeat (sdly) begin
            check("no_early_fill", fill_valid, 0);
            @(negedge clk);
        end
        d            = rand_line();
        l2_rsp_valid = 1'b1;
        l2_rsp_data  = d;
        @(negedge clk);
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = rand_line();
        check("fill_valid", fill_valid, 1);
        check("fill_set", fill_set, s);
        check("fill_way", fill_way, vw);
        check("fill_data", fill_data, d);
        check("resp_valid_fill", resp_valid, 1);
        check("resp_hit_fill", resp_hit, 0);
        check("resp_way_fill", resp_way, vw);
        check("resp_err_fill", resp_err, 0);
        mvalid[s][vw] = 1'b1;
        mtag[s][vw]   = t;
        m_touch(s, vw);
        got_way = vw;
        @(negedge clk);
        check("fill_pulse", fill_valid, 0);
        check("ready_after_fill", lookup_ready, 1);
    endtask

    initial begin
        int w;
        logic [15:0] a;
        rst          = 1'b1;
        lookup_valid = 1'b0;
        lookup_addr  = '0;
        l2_req_ready = 1'b0;
        l2_rsp_valid = 1'b0;
        l2_rsp_data  = '0;
        m_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_lookup_ready", lookup_ready, 1);
        check("reset_resp_valid", resp_valid, 0);
        check("reset_resp_err", resp_err, 0);
        check("reset_l2_req_valid", l2_req_valid, 0);
        check("reset_l2_req_addr", l2_req_addr, 0);
        check("reset_fill_valid", fill_valid, 0);
        check("reset_fill_data", fill_data, 0);

        do_lookup(16'h1240, 0, 1, 0, w);
        check("tp_first_fill_way", w, 0);
        do_lookup(16'h125F, 0, 0, 0, w);
        check("tp_rehit_way", w, 0);
        for (int k = 1; k <= 3; k++) begin
            a = {7'(k), 4'd2, 5'd0};
            do_lookup(a, 0, 0, 0, w);
            check("tp_set2_fill_way", w, k);
        end
        do_lookup({7'd4, 4'd2, 5'd3}, 0, 0, 0, w);
        check("tp_plru_victim_way0", w, 0);

        do_lookup({7'd5, 4'd7, 5'd0}, 5, 0, 0, w);

        do_lookup(16'h3460, 0, 0, 1, w);
        do_lookup(16'h3460, 0, 0, 0, w);
        do_lookup(16'h1240, 0, 0, 0, w);
        check("tp_miss_after_reset_way", w, 0);

`ifdef L2_TIMEOUT_EN
        do_lookup({7'd9, 4'd11, 5'd0}, 0, 0, 2, w);
        do_lookup({7'd9, 4'd11, 5'd0}, 0, 0, 0, w);
`else
        do_lookup({7'd9, 4'd11, 5'd0}, 0, 80, 0, w);
`endif

        for (int i = 0; i < 150; i++) begin
            a = {7'($urandom_range(0, 5)), 4'($urandom_range(0, 3)), 5'($urandom)};
            do_lookup(a, $urandom_range(0, 3), $urandom_range(0, 3), 0, w);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_l2_refill_ctrl.md
Name: l1_l2_refill_ctrl

Overview:
Parametrised L1 tag/replacement controller and L2 refill engine. It sits between the L1 lookup pipeline and the L2 request port.
- Holds the valid and tag arrays and per-set bit-PLRU state for an N-way set-associative L1.
- Resolves one lookup at a time as hit or miss.
- On a miss, picks a victim, issues a line request to L2 with a valid/ready handshake, waits for the response, and drives the fill to the external L1 data array.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 256, line width in bits; OFFSET_W = log2(LINE_W/8) = 5.
- NUM_SETS, 16, sets (power of 2); INDEX_W = log2(NUM_SETS) = 4.
- NUM_WAYS, 4, ways per set (power of 2, 2..32); WAY_W = log2(NUM_WAYS).
- TIMEOUT_CYCLES, 64, L2 response watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- lookup_valid  in  1  lookup request.
- lookup_ready  out  1  high only in IDLE.
- lookup_addr  in  ADDR_W  byte address.
- resp_valid  out  1  one-cycle pulse at lookup completion.
- resp_hit  out  1  1 = hit, 0 = refilled miss.
- resp_way  out  WAY_W  way that hit or was filled.
- resp_err  out  1  L2 timeout (tied 0 without the optional feature).
- l2_req_valid  out  1  L2 request.
- l2_req_ready  in  1  L2 accepts request.
- l2_req_addr  out  ADDR_W  line-aligned address; offset bits are 0.
- l2_rsp_valid  in  1  L2 data return.
- l2_rsp_data  in  LINE_W  refill line.
- fill_valid  out  1  one-cycle data-array write strobe.
- fill_set  out  INDEX_W  fill set.
- fill_way  out  WAY_W  fill way.
- fill_data  out  LINE_W  fill line.

Behaviour:
- Address split: tag = addr[ADDR_W-1 : OFFSET_W+INDEX_W] (TAG_W = 7 at defaults); index = addr[OFFSET_W+INDEX_W-1 : OFFSET_W].
- Reset:
  - State goes to IDLE.
  - All valid bits and PLRU bits clear; tag contents are don't-care.
  - All outputs are 0 except lookup_ready, which is 1.
  - Any in-flight request is abandoned. An l2_rsp_valid arriving after reset is ignored.
- State IDLE:
  - The lookup is accepted when lookup_valid && lookup_ready; the address is latched.
  - Next state is COMPARE. l2_rsp_valid is ignored in IDLE.
- State COMPARE (1 cycle):
  - Compare the tag against all valid ways of the indexed set.
  - Hit: resp_valid=1, resp_hit=1, resp_way=matching way; PLRU is touched; next state IDLE. Hit latency is 2 cycles from accept to resp_valid.
  - Miss: victim = lowest-index invalid way; if none is invalid, the lowest-index way with PLRU bit 0. Next state REQ.
- State REQ:
  - l2_req_valid=1 and l2_req_addr are held stable until l2_req_ready is sampled high, then go to WAIT.
  - Deasserting l2_req_valid before the handshake completes is not allowed.
- State WAIT:
  - On l2_rsp_valid, capture the data and go to FILL.
  - A response in the same cycle as the request handshake belongs to the next cycle's WAIT; L2 must not return data before acceptance.
- State FILL (1 cycle):
  - fill_valid=1 with fill_set, fill_way = victim and fill_data.
  - Write the tag, set the valid bit, touch PLRU.
  - resp_valid=1, resp_hit=0, resp_way=victim; next state IDLE.
- PLRU touch(set, w):
  - Set bit[w]=1.
  - If that would make all NUM_WAYS bits 1, clear every bit except w.
  - Only touched on a hit or a fill.
- Back-to-back: lookup_ready rises in the cycle after resp_valid, so there is no overlap.
- Simultaneous events: a lookup to the set currently being filled is blocked by lookup_ready=0 and sees the new tag afterwards.

Optional Feature:
- L2_TIMEOUT_EN defined:
  - A counter runs in WAIT and resets on entering WAIT.
  - If it reaches TIMEOUT_CYCLES without l2_rsp_valid, pulse resp_valid=1, resp_err=1, resp_hit=0 and go to IDLE.
  - No fill and no tag/PLRU update occur.
  - A late response is ignored in IDLE.
- L2_TIMEOUT_EN undefined: WAIT is unbounded, resp_err is constant 0, and no counter is built.

Decomposition:
- Package l1_l2_pkg holds:
  - the state enum (IDLE, COMPARE, REQ, WAIT, FILL);
  - default width constants;
  - tag/index/offset extract functions.
- Sub-module plru_bits: one set's NUM_WAYS bits, with touch and victim-select logic, instantiated per set via generate. Victim select includes the invalid-way priority input.

Test Plan:
- After reset, lookup 0x1240 → miss; l2_req_addr=0x1240, then a response → fill_set=2, fill_way=0, resp_hit=0.
- Re-lookup 0x125F → resp_hit=1, resp_way=0, 2 cycles after accept, no L2 request.
- Fill ways 0,1,2 of set 2 with distinct tags, then a 4th miss → fill_way=3; PLRU bits become 1000 (only way 3 set). A 5th distinct-tag miss → victim way 0.
- Hold l2_req_ready=0 for 5 cycles → l2_req_valid and l2_req_addr stay stable, and no extra requests are issued.
- Assert rst while in WAIT → outputs return to reset values; a later l2_rsp_valid produces no fill; a re-lookup misses again.
- With L2_TIMEOUT_EN, no response for 64 cycles → resp_err=1 pulse, no fill_valid, lookup_ready=1 on the next cycle.
